friscv_cache_line_loader: RTL and testbench

// - Sits directly after the instruction-cache block fetcher, between it and central memory.
// - Queues cache-miss addresses and issues one single-beat AXI4 read per miss to central memory.
// - Writes the returned block into the cache lines, and pulses cache_writing so the fetcher replays the missed read.

---
 rtl/friscv_h.sv | 22 ++
 rtl/friscv_scfifo.sv | 80 ++++++++
 rtl/friscv_cache_line_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_friscv_cache_line_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_h.sv
// ----------------------------------------------------------------------------
// friscv_h
// Shared definitions for the instruction-cache line loader:
//   - loader_state_t : FSM states of friscv_cache_line_loader
//   - INCR / OKAY    : AXI4 burst type and response encodings
// ----------------------------------------------------------------------------
package friscv_h;

    // Line loader FSM: one AXI read in flight at most, DRAIN absorbs
    // the response of a request cancelled by flush.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARREQ = 3'd1,
        RWAIT = 3'd2,
        WRITE = 3'd3,
        DRAIN = 3'd4
    } loader_state_t;

    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/friscv_scfifo.sv
// ----------------------------------------------------------------------------
// friscv_scfifo
// Single-clock FIFO of 2**ADDR_WIDTH entries.
//   PASS_THRU = 0 : data becomes visible the cycle after the push.
//   PASS_THRU = 1 : a push into an empty FIFO is visible on data_out in the
//                   same cycle and can be pulled without being stored.
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high)
//   flush         : empties the FIFO in the cycle it is asserted
//   data_in, push : write side; a push while full is dropped
//   full          : no free entry
//   data_out, pull: read side, data_out is the head entry
//   empty         : no entry available
// ----------------------------------------------------------------------------
module friscv_scfifo #(
    parameter int PASS_THRU  = 0,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
)(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  pull,
    output logic                  empty
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  int_empty;
    logic                  bypass;
    logic                  do_push;
    logic                  do_pull;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign int_empty = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                       (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    // Bypass only exists in pass-through mode; a bypassed word that is
    // pulled immediately never occupies an entry.
    assign bypass   = (PASS_THRU != 0) && int_empty && push;
    assign do_push  = push && !full && !(bypass && pull);
    assign do_pull  = pull && !int_empty;
    assign empty    = int_empty && !bypass;
    assign data_out = bypass ? data_in : mem[rd_ptr[ADDR_WIDTH-1:0]];

    // Read and write pointers; flush and srst both return to empty.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (srst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pull) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array, not reset: an entry is only read after it was written.
    always_ff @(posedge aclk) begin
        if (do_push && !flush && !srst) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/friscv_cache_line_loader.sv
// ----------------------------------------------------------------------------
// friscv_cache_line_loader
// Sits between the instruction-cache block fetcher and central memory.
// Cache misses are queued, each is served by one single-beat AXI4 read and
// the returned block is written into the cache; cache_writing tells the
// fetcher to replay the missed read.
//
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high)
//   flush                          : drop queued misses, discard in-flight data
//   miss_valid/miss_addr/miss_prot : miss request (one-cycle pulse)
//   miss_full                      : miss queue full
//   ar*                            : AXI4 read address channel (master)
//   r*                             : AXI4 read data channel (rid/rlast ignored)
//   cache_writing/cache_wen/cache_waddr/cache_wdata : cache line write
//   mem_err                        : pulses with the write when rresp != OKAY
//
// Configuration macro:
//   LOADER_PERF_EN : adds output miss_count[31:0], counting line writes and
//                    dropped/drained requests.
// ----------------------------------------------------------------------------
module friscv_cache_line_loader
    import friscv_h::*;
#(
    parameter int                  OSTDREQ_NUM = 4,
    parameter int                  AXI_ADDR_W  = 32,
    parameter int                  AXI_ID_W    = 8,
    parameter int                  AXI_DATA_W  = 128,
    parameter logic [AXI_ID_W-1:0] AXI_ID_MASK = 'h10
)(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  flush,
    input  logic                  miss_valid,
    input  logic [AXI_ADDR_W-1:0] miss_addr,
    input  logic [2:0]            miss_prot,
    output logic                  miss_full,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [AXI_ADDR_W-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic [AXI_ID_W-1:0]   arid,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [AXI_ID_W-1:0]   rid,
    input  logic [1:0]            rresp,
    input  logic [AXI_DATA_W-1:0] rdata,
    input  logic                  rlast,
    output logic                  cache_writing,
    output logic                  cache_wen,
    output logic [AXI_ADDR_W-1:0] cache_waddr,
    output logic [AXI_DATA_W-1:0] cache_wdata,
    output logic                  mem_err
`ifdef LOADER_PERF_EN
    ,
    output logic [31:0]           miss_count
`endif
);

    localparam int OFFSET_W = $clog2(AXI_DATA_W/8);
    localparam int FIFO_AW  = $clog2(OSTDREQ_NUM);
    localparam int FIFO_DW  = AXI_ADDR_W + 3;
    localparam logic [AXI_ADDR_W-1:0] LINE_MASK = {AXI_ADDR_W{1'b1}} << OFFSET_W;

    loader_state_t          state;
    loader_state_t          state_next;

    logic                   fifo_push;
    logic                   fifo_pull;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_DW-1:0]     fifo_out;

    logic                   latch_req;
    logic                   latch_rdata;
    logic                   drop_evt;

    logic [AXI_ADDR_W-1:0]  araddr_q;
    logic [2:0]             arprot_q;
    logic [AXI_DATA_W-1:0]  rdata_q;
    logic                   resp_err_q;
    logic                   flush_seen_q;

    // rid is not checked (only one read in flight) and rlast is implied by arlen=0.
    logic                   unused_axi;
    assign unused_axi = ^{rid, rlast};

    // Miss queue: a flush cycle never enqueues the incoming miss.
    assign fifo_push = miss_valid && !flush;

    friscv_scfifo #(
        .PASS_THRU  (0),
        .ADDR_WIDTH (FIFO_AW),
        .DATA_WIDTH (FIFO_DW)
    ) miss_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .flush    (flush),
        .data_in  ({miss_prot, miss_addr}),
        .push     (fifo_push),
        .full     (fifo_full),
        .data_out (fifo_out),
        .pull     (fifo_pull),
        .empty    (fifo_empty)
    );

    // Next-state logic. A flush seen while arvalid is up cannot withdraw the
    // request, so the response is absorbed in DRAIN instead.
    always_comb begin
        state_next  = state;
        fifo_pull   = 1'b0;
        latch_req   = 1'b0;
        latch_rdata = 1'b0;
        drop_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !flush) begin
                    fifo_pull  = 1'b1;
                    latch_req  = 1'b1;
                    state_next = ARREQ;
                end
            end
            ARREQ: begin
                if (arready) begin
                    state_next = (flush || flush_seen_q) ? DRAIN : RWAIT;
                end
            end
            RWAIT: begin
                if (rvalid) begin
                    if (flush) begin
                        drop_evt   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        latch_rdata = 1'b1;
                        state_next  = WRITE;
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            DRAIN: begin
                if (rvalid) begin
                    drop_evt   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; srst aborts any transaction since the slave is reset too.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else if (srst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request and response holding registers. The address is line-aligned
    // when latched so AR and the cache write share the same value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            araddr_q     <= '0;
            arprot_q     <= '0;
            rdata_q      <= '0;
            resp_err_q   <= 1'b0;
            flush_seen_q <= 1'b0;
        end else if (srst) begin
            araddr_q     <= '0;
            arprot_q     <= '0;
            rdata_q      <= '0;
            resp_err_q   <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            if (latch_req) begin
                araddr_q <= fifo_out[AXI_ADDR_W-1:0] & LINE_MASK;
                arprot_q <= fifo_out[FIFO_DW-1 -: 3];
            end
            if (latch_rdata) begin
                rdata_q    <= rdata;
                resp_err_q <= (rresp != OKAY);
            end
            if (state == ARREQ) begin
                flush_seen_q <= flush_seen_q | flush;
            end else begin
                flush_seen_q <= 1'b0;
            end
        end
    end

    assign miss_full     = fifo_full;
    assign arvalid       = (state == ARREQ);
    assign araddr        = araddr_q;
    assign arprot        = arprot_q;
    assign arlen         = 8'd0;
    assign arsize        = 3'(OFFSET_W);
    assign arburst       = INCR;
    assign arcache       = 4'd0;
    assign arid          = AXI_ID_MASK;
    assign rready        = (state == RWAIT) || (state == DRAIN);
    assign cache_wen     = (state == WRITE);
    assign cache_writing = (state == WRITE);
    assign cache_waddr   = araddr_q;
    assign cache_wdata   = rdata_q;
    assign mem_err       = (state == WRITE) && resp_err_q;

`ifdef LOADER_PERF_EN
    // Counts every request that left the loader, written or discarded.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            miss_count <= '0;
        end else if (srst) begin
            miss_count <= '0;
        end else if ((state == WRITE) || drop_evt) begin
            miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_friscv_cache_line_loader.sv
// ----------------------------------------------------------------------------
// tb_friscv_cache_line_loader
// Directed and randomized stimulus for friscv_cache_line_loader. The bench
// plays the AXI slave; expected AR addresses and cache writes come from a
// queue of issued misses, aligned arithmetically to the 16-byte line.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_friscv_cache_line_loader;

    localparam int AW = 32;
    localparam int IW = 8;
    localparam int DW = 128;
    localparam int LINE_BYTES = DW / 8;
    localparam int QDEPTH = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          srst;
    logic          flush;
    logic          miss_valid;
    logic [AW-1:0] miss_addr;
    logic [2:0]    miss_prot;
    logic          miss_full;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic [IW-1:0] arid;
    logic          rvalid;
    logic          rready;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic          cache_writing;
    logic          cache_wen;
    logic [AW-1:0] cache_waddr;
    logic [DW-1:0] cache_wdata;
    logic          mem_err;
`ifdef LOADER_PERF_EN
    logic [31:0]   miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    prot;
    } miss_t;

    // Misses the loader is expected to serve, in order.
    miss_t exp_q[$];

    always #5 aclk = ~aclk;

    friscv_cache_line_loader dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .srst          (srst),
        .flush         (flush),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_prot     (miss_prot),
        .miss_full     (miss_full),
        .arvalid       (arvalid),
        .arready       (arready),
        .araddr        (araddr),
        .arlen         (arlen),
        .arsize        (arsize),
        .arburst       (arburst),
        .arcache       (arcache),
        .arprot        (arprot),
        .arid          (arid),
        .rvalid        (rvalid),
        .rready        (rready),
        .rid           (rid),
        .rresp         (rresp),
        .rdata         (rdata),
        .rlast         (rlast),
        .cache_writing (cache_writing),
        .cache_wen     (cache_wen),
        .cache_waddr   (cache_waddr),
        .cache_wdata   (cache_wdata),
`ifdef LOADER_PERF_EN
        .miss_count    (miss_count),
`endif
        .mem_err       (mem_err)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge aclk);
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        return (a / LINE_BYTES) * LINE_BYTES;
    endfunction

    // One-cycle miss pulse; keep=1 records it as a miss that must be served.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [2:0] prot,
                                 input bit keep);
        miss_t m;
        m.addr = addr;
        m.prot = prot;
        if (keep) exp_q.push_back(m);
        miss_valid = 1'b1;
        miss_addr  = addr;
        miss_prot  = prot;
        step();
        miss_valid = 1'b0;
    endtask

    task automatic wait_arvalid(input string tag);
        int n = 0;
        while (arvalid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checkOutput(tag, arvalid, 1);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_arvalid"}, arvalid, 0);
        checkOutput({tag, "_rready"}, rready, 0);
        checkOutput({tag, "_cache_wen"}, cache_wen, 0);
        checkOutput({tag, "_cache_writing"}, cache_writing, 0);
        checkOutput({tag, "_mem_err"}, mem_err, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkQuiet(tag);
        checkOutput({tag, "_miss_full"}, miss_full, 0);
        checkOutput({tag, "_araddr"}, araddr, 0);
        checkOutput({tag, "_arprot"}, arprot, 0);
        checkOutput({tag, "_cache_waddr"}, cache_waddr, 0);
        checkOutput({tag, "_cache_wdata"}, cache_wdata, 0);
        checkOutput({tag, "_arlen"}, arlen, 0);
        checkOutput({tag, "_arsize"}, arsize, 4);
        checkOutput({tag, "_arburst"}, arburst, 2'b01);
        checkOutput({tag, "_arcache"}, arcache, 0);
        checkOutput({tag, "_arid"}, arid, 'h10);
    endtask

    // Acts as the AXI slave for the oldest expected miss and checks the
    // AR request, the single outstanding read and the one-cycle line write.
    task automatic serve_one(input int ar_delay, input int r_delay,
                             input logic [DW-1:0] data, input logic [1:0] resp);
        miss_t         m;
        logic [AW-1:0] line;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL model_empty observed=0 expected=1 pending misses");
            return;
        end
        m    = exp_q.pop_front();
        line = line_of(m.addr);
        wait_arvalid("ar_wait");
        checkOutput("araddr", araddr, line);
        checkOutput("arprot", arprot, m.prot);
        checkOutput("arlen", arlen, 0);
        checkOutput("arsize", arsize, 4);
        checkOutput("arburst", arburst, 2'b01);
        checkOutput("arid", arid, 'h10);
        for (int i = 0; i < ar_delay; i++) begin
            step();
            checkOutput("arvalid_hold", arvalid, 1);
            checkOutput("araddr_hold", araddr, line);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        checkOutput("ar_done_arvalid", arvalid, 0);
        checkOutput("rready", rready, 1);
        for (int i = 0; i < r_delay; i++) begin
            step();
            checkOutput("one_outstanding", arvalid, 0);
            checkOutput("rready_wait", rready, 1);
        end
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        rid    = IW'($urandom);
        rlast  = 1'b1;
        step();
        rvalid = 1'b0;
        checkOutput("cache_wen", cache_wen, 1);
        checkOutput("cache_writing", cache_writing, 1);
        checkOutput("cache_waddr", cache_waddr, line);
        checkOutput("cache_wdata", cache_wdata, data);
        checkOutput("mem_err", mem_err, resp != 2'b00);
        checkOutput("write_one_outstanding", arvalid, 0);
        step();
        checkOutput("wen_one_cycle", cache_wen, 0);
        checkOutput("mem_err_pulse", mem_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        int            k;
        aresetn    = 1'b0;
        srst       = 1'b0;
        flush      = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = '0;
        miss_prot  = '0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rid        = '0;
        rresp      = '0;
        rdata      = '0;
        rlast      = 1'b0;

        // Reset state, during and after reset.
        repeat (3) step();
        checkResetState("reset");
        aresetn = 1'b1;
        step();
        checkResetState("post_reset");

        // Single miss: 2-cycle AR latency, line-aligned address, one write.
        $display("[TB] single miss at 0x1004");
        applyStimulus(32'h1004, 3'b010, 1'b1);
        checkOutput("latency_cycle1", arvalid, 0);
        step();
        checkOutput("latency_cycle2", arvalid, 1);
        serve_one(0, 3, {16{8'hA5}}, 2'b00);
        step();
        checkQuiet("after_single");

        // Three back-to-back misses, served strictly one at a time.
        $display("[TB] back-to-back misses");
        applyStimulus(32'h2000, 3'b000, 1'b1);
        applyStimulus(32'h3010, 3'b001, 1'b1);
        applyStimulus(32'h4020, 3'b100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            serve_one(i, 1, {$urandom, $urandom, $urandom, $urandom}, 2'b00);
        end
        repeat (4) begin
            step();
            checkQuiet("after_b2b");
        end

        // Flush in ARREQ: request held, response drained, queue discarded.
        $display("[TB] flush during address phase");
        applyStimulus(32'h5004, 3'b000, 1'b0);
        wait_arvalid("flush_ar_wait");
        applyStimulus(32'h6000, 3'b000, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("flush_arvalid_hold", arvalid, 1);
            checkOutput("flush_araddr_hold", araddr, 32'h5000);
            step();
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        checkOutput("drain_rready", rready, 1);
        step();
        checkOutput("drain_no_wen", cache_wen, 0);
        rvalid = 1'b1;
        rdata  = {4{32'hDEADBEEF}};
        rresp  = 2'b00;
        step();
        rvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkQuiet("after_drain");
            step();
        end

        // Queue capacity with the slave stalled: one miss is taken by the
        // loader, QDEPTH more fit in the queue, the rest is dropped.
        $display("[TB] queue full");
        for (int i = 0; i < QDEPTH + 2; i++) begin
            applyStimulus(32'h0001_0000 + 32'(i) * 32'h100 + 32'h8, 3'(i),
                          exp_q.size() < QDEPTH + 1);
            checkOutput("miss_full", miss_full, (i >= QDEPTH));
        end
        for (int i = 0; i < QDEPTH + 1; i++) begin
            serve_one(0, 0, {$urandom, $urandom, $urandom, $urandom}, 2'b00);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checkQuiet("dropped_miss_not_served");
        end
        checkOutput("miss_full_cleared", miss_full, 0);

        // Error response still writes the line and flags mem_err.
        $display("[TB] error response");
        applyStimulus(32'h0000_7ABC, 3'b011, 1'b1);
        serve_one(1, 2, {4{32'h0BAD_F00D}}, 2'b10);

        // Asynchronous reset during RWAIT, then a normal miss.
        $display("[TB] async reset during read wait");
        applyStimulus(32'h0000_8008, 3'b000, 1'b0);
        wait_arvalid("rst_ar_wait");
        arready = 1'b1;
        step();
        arready = 1'b0;
        checkOutput("rst_in_rwait", rready, 1);
        #2;
        aresetn = 1'b0;
        #1;
        checkResetState("async_reset");
        step();
        aresetn = 1'b1;
        step();
        applyStimulus(32'h0000_9034, 3'b110, 1'b1);
        serve_one(0, 1, {$urandom, $urandom, $urandom, $urandom}, 2'b00);

        // Synchronous reset while the request is pending.
        $display("[TB] srst during address phase");
        applyStimulus(32'h0000_A000, 3'b000, 1'b0);
        wait_arvalid("srst_ar_wait");
        srst = 1'b1;
        step();
        srst = 1'b0;
        checkResetState("srst");
        for (int i = 0; i < 4; i++) begin
            step();
            checkQuiet("after_srst");
        end

        // Randomized misses, grouped in bursts of 1..3, random slave timing.
        $display("[TB] randomized misses");
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                applyStimulus($urandom, 3'($urandom_range(0, 7)), 1'b1);
            end
            for (int j = 0; j < k; j++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                serve_one($urandom_range(0, 3), $urandom_range(0, 3), d,
                          2'($urandom_range(0, 3)));
            end
        end
        step();
        checkQuiet("final");
        checkOutput("model_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
